// File: rtl/alu_commit_arbiter_if.sv
// rtl/alu_commit_arbiter_if.sv - ALU result, writeback and trap signal bundle for the commit arbiter
interface alu_commit_arbiter_if #(
  parameter int N_UNITS    = 4,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int IDX_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0]            unit_valid;
  logic [N_UNITS*XLEN-1:0]       unit_res;
  logic [N_UNITS*REG_ADDR_W-1:0] unit_rd;
  logic [N_UNITS-1:0]            unit_error;
  logic [N_UNITS-1:0]            unit_clear;
  logic                          wb_en;
  logic [REG_ADDR_W-1:0]         wb_rd;
  logic [XLEN-1:0]               wb_data;
  logic                          exc_valid;
  logic [IDX_W-1:0]              exc_unit;
  logic                          exc_ack;
  logic                          flush;
  logic                          halted;

  // ALU side plus trap logic: produces results and control, consumes grants/writes.
  modport master (
    output unit_valid, unit_res, unit_rd, unit_error, exc_ack, flush,
    input  unit_clear, wb_en, wb_rd, wb_data, exc_valid, exc_unit, halted
  );

  // Arbiter side.
  modport slave (
    input  unit_valid, unit_res, unit_rd, unit_error, exc_ack, flush,
    output unit_clear, wb_en, wb_rd, wb_data, exc_valid, exc_unit, halted
  );
endinterface

// File: rtl/alu_commit_arbiter.sv
// rtl/alu_commit_arbiter.sv - round-robin commit arbiter from ALU units to the register-file write port
module alu_commit_arbiter #(
  parameter int N_UNITS    = 4,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_commit_arbiter_if.slave io_bus
);
  localparam int IDX_W = $clog2(N_UNITS);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [N_UNITS-1:0]    r_mask;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_exc_valid;
  logic [IDX_W-1:0]      r_exc_unit;

  logic [N_UNITS-1:0]    w_eligible;
  logic                  w_grant_vld;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [IDX_W:0]        w_probe;
  logic [XLEN-1:0]       w_sel_res;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic                  w_sel_err;
  logic                  w_do_write;
  logic [IDX_W-1:0]      w_ptr_nxt;

  // A unit may compete only in RUN, outside a flush, and if it was not granted last cycle
  // (the mask hides a unit that has not yet dropped valid after its clear).
  always_comb begin
    w_eligible = io_bus.unit_valid & ~r_mask
               & {N_UNITS{(r_state == ST_RUN) && !io_bus.flush}};
  end

  // Round-robin search starting at rr_ptr; the probe index wraps modulo N_UNITS.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_probe     = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      w_probe = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_probe >= (IDX_W+1)'(N_UNITS)) begin
        w_probe = w_probe - (IDX_W+1)'(N_UNITS);
      end
      if (!w_grant_vld && w_eligible[w_probe[IDX_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_probe[IDX_W-1:0];
      end
    end
  end

  // Mux out the granted unit's result and derive the commit decision.
  always_comb begin
    w_sel_res  = io_bus.unit_res[int'(w_grant_idx)*XLEN +: XLEN];
    w_sel_rd   = io_bus.unit_rd[int'(w_grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    w_sel_err  = io_bus.unit_error[w_grant_idx];
    w_do_write = w_grant_vld && !w_sel_err && (w_sel_rd != '0);
    w_ptr_nxt  = (w_grant_idx == IDX_W'(N_UNITS-1)) ? '0 : w_grant_idx + 1'b1;
  end

  // Grant/clear goes back to the unit in the same cycle; forced low while in reset.
  always_comb begin
    io_bus.unit_clear = '0;
    if (w_grant_vld && rst_n) begin
      io_bus.unit_clear = N_UNITS'(1) << w_grant_idx;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a faulty commit halts; ack or flush resumes; flush always wins.
  always_comb begin
    w_state_nxt = r_state;
    if (io_bus.flush) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_grant_vld && w_sel_err) w_state_nxt = ST_HALT;
        ST_HALT: if (io_bus.exc_ack)           w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Registered commit: write pulse, exception pulse, pointer advance and one-cycle mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_unit  <= '0;
      r_rr_ptr    <= '0;
      r_mask      <= '0;
    end else begin
      r_wb_en     <= w_do_write;
      r_exc_valid <= w_grant_vld && w_sel_err;
      if (w_do_write) begin
        r_wb_rd   <= w_sel_rd;
        r_wb_data <= w_sel_res;
      end
      if (w_grant_vld && w_sel_err) begin
        r_exc_unit <= w_grant_idx;
      end
      if (w_grant_vld) begin
        r_rr_ptr <= w_ptr_nxt;
        r_mask   <= N_UNITS'(1) << w_grant_idx;
      end else begin
        r_mask   <= '0;
      end
    end
  end

  assign io_bus.wb_en     = r_wb_en;
  assign io_bus.wb_rd     = r_wb_rd;
  assign io_bus.wb_data   = r_wb_data;
  assign io_bus.exc_valid = r_exc_valid;
  assign io_bus.exc_unit  = r_exc_unit;
  assign io_bus.halted    = (r_state == ST_HALT);
endmodule

// File: tb/tb_alu_commit_arbiter.sv
// tb/tb_alu_commit_arbiter.sv - scoreboard bench for the ALU commit arbiter
module tb_alu_commit_arbiter;
  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_commit_arbiter_if #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) bus();

  alu_commit_arbiter #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [XL-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic v, input logic [RW-1:0] rd,
                          input logic [XL-1:0] res, input logic err);
    bus.unit_valid[i]           = v;
    bus.unit_rd[i*RW +: RW]     = rd;
    bus.unit_res[i*XL +: XL]    = res;
    bus.unit_error[i]           = err;
  endtask

  // Scoreboard: every write pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && bus.wb_en === 1'b1) begin
      wb_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", bus.wb_rd, bus.wb_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_commit: got rd=%0d data=%h, required rd=%0d data=%h",
                   bus.wb_rd, bus.wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    bus.unit_valid = '0; bus.unit_res = '0; bus.unit_rd = '0; bus.unit_error = '0;
    bus.exc_ack = 1'b0; bus.flush = 1'b0;
    rst_n = 1'b0;
    bus.unit_valid = 4'b0001;
    #12;
    checks++; if (bus.unit_clear !== 4'b0000) begin errors++; $display("FAIL reset_clear: got %b required 0000", bus.unit_clear); end
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b required 0", bus.wb_en); end
    checks++; if (bus.wb_rd !== '0 || bus.wb_data !== '0) begin errors++; $display("FAIL reset_wb_bus: got rd=%0d data=%h required 0", bus.wb_rd, bus.wb_data); end
    checks++; if (bus.exc_valid !== 1'b0 || bus.exc_unit !== '0) begin errors++; $display("FAIL reset_exc: got %b/%0d required 0/0", bus.exc_valid, bus.exc_unit); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", bus.halted); end
    bus.unit_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_unit(1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    #1;
    checks++; if (bus.unit_clear !== 4'b0010) begin errors++; $display("FAIL single_clear: got %b required 0010", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick();
    bus.unit_valid[1] = 1'b0;
    checks++; if (bus.wb_en !== 1'b1) begin errors++; $display("FAIL single_wb_en: got %b required 1", bus.wb_en); end
    tick();
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL single_wb_pulse: got %b required 0", bus.wb_en); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_clr;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_unit(i, 1'b1, RW'(i+1), 32'h100 + 32'(i), 1'b0);
    #1;
    for (int c = 0; c < 2*N; c++) begin
      exp_clr = '0;
      exp_clr[c % N] = 1'b1;
      checks++; if (bus.unit_clear !== exp_clr) begin errors++; $display("FAIL fair_clear[%0d]: got %b required %b", c, bus.unit_clear, exp_clr); end
      exp_q.push_back('{rd: RW'((c % N) + 1), data: 32'h100 + 32'(c % N)});
      tick();
    end
    bus.unit_valid = '0;
    tick();
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL fair_idle: got %b required 0", bus.wb_en); end
  endtask

  task automatic test_x0();
    set_unit(2, 1'b1, 5'd0, 32'h1234, 1'b0);
    #1;
    checks++; if (bus.unit_clear !== 4'b0100) begin errors++; $display("FAIL x0_clear: got %b required 0100", bus.unit_clear); end
    tick();
    bus.unit_valid[2] = 1'b0;
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL x0_wb_en: got %b required 0", bus.wb_en); end
    checks++; if (bus.wb_rd !== 5'd4 || bus.wb_data !== 32'h103) begin errors++; $display("FAIL x0_hold: got rd=%0d data=%h required rd=4 data=103", bus.wb_rd, bus.wb_data); end
  endtask

  task automatic test_error();
    set_unit(3, 1'b1, 5'd6, 32'hBAD, 1'b1);
    #1;
    checks++; if (bus.unit_clear !== 4'b1000) begin errors++; $display("FAIL err_clear: got %b required 1000", bus.unit_clear); end
    tick();
    set_unit(3, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++; if (bus.exc_valid !== 1'b1 || bus.exc_unit !== 2'd3) begin errors++; $display("FAIL err_exc: got %b/%0d required 1/3", bus.exc_valid, bus.exc_unit); end
    checks++; if (bus.halted !== 1'b1 || bus.wb_en !== 1'b0) begin errors++; $display("FAIL err_halt: got halted=%b wb_en=%b required 1/0", bus.halted, bus.wb_en); end
    set_unit(0, 1'b1, 5'd7, 32'hA5A5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.unit_clear !== 4'b0000 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d]: got clear=%b halted=%b required 0000/1", c, bus.unit_clear, bus.halted); end
      tick();
      checks++; if (bus.exc_valid !== 1'b0) begin errors++; $display("FAIL exc_pulse[%0d]: got %b required 0", c, bus.exc_valid); end
    end
    bus.exc_ack = 1'b1;
    #1;
    checks++; if (bus.unit_clear !== 4'b0000) begin errors++; $display("FAIL ack_cycle_clear: got %b required 0000", bus.unit_clear); end
    tick();
    bus.exc_ack = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0 || bus.unit_clear !== 4'b0001) begin errors++; $display("FAIL ack_resume: got halted=%b clear=%b required 0/0001", bus.halted, bus.unit_clear); end
    exp_q.push_back('{rd: 5'd7, data: 32'hA5A5});
    tick();
    bus.unit_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    set_unit(0, 1'b1, 5'd10, 32'hF0, 1'b0);
    set_unit(1, 1'b1, 5'd11, 32'hF1, 1'b0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.unit_clear !== 4'b0000) begin errors++; $display("FAIL flush_clear: got %b required 0000", bus.unit_clear); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en: got %b required 0", bus.wb_en); end
    #1;
    checks++; if (bus.unit_clear !== 4'b0010) begin errors++; $display("FAIL flush_resume: got %b required 0010", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd11, data: 32'hF1});
    tick();
    bus.unit_valid[1] = 1'b0;
    #1;
    checks++; if (bus.unit_clear !== 4'b0001) begin errors++; $display("FAIL flush_next: got %b required 0001", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd10, data: 32'hF0});
    tick();
    bus.unit_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    set_unit(1, 1'b1, 5'd9, 32'h77, 1'b0);
    #1;
    checks++; if (bus.unit_clear !== 4'b0010) begin errors++; $display("FAIL rst_pre_clear: got %b required 0010", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd9, data: 32'h77});
    tick();
    bus.unit_valid[1] = 1'b0;
    checks++; if (bus.wb_en !== 1'b1) begin errors++; $display("FAIL rst_pre_wb_en: got %b required 1", bus.wb_en); end
    #5;
    rst_n = 1'b0;
    set_unit(0, 1'b1, 5'd12, 32'hC0, 1'b0);
    set_unit(2, 1'b1, 5'd13, 32'hC2, 1'b0);
    #1;
    checks++; if (bus.wb_en !== 1'b0 || bus.wb_rd !== '0 || bus.wb_data !== '0) begin errors++; $display("FAIL rst_async_wb: got en=%b rd=%0d data=%h required 0", bus.wb_en, bus.wb_rd, bus.wb_data); end
    checks++; if (bus.unit_clear !== 4'b0000) begin errors++; $display("FAIL rst_async_clear: got %b required 0000", bus.unit_clear); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.unit_clear !== 4'b0001) begin errors++; $display("FAIL rst_rearb: got %b required 0001", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd12, data: 32'hC0});
    tick();
    bus.unit_valid[0] = 1'b0;
    #1;
    checks++; if (bus.unit_clear !== 4'b0100) begin errors++; $display("FAIL rst_rearb_next: got %b required 0100", bus.unit_clear); end
    exp_q.push_back('{rd: 5'd13, data: 32'hC2});
    tick();
    bus.unit_valid[2] = 1'b0;
    tick();
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b required 0", bus.wb_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_error();
    test_flush();
    test_async_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending commits, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
